testpattern_gen: RTL and testbench
==================================

// Module: testpattern_gen
// PURPOSE
//  Parametrised, multi-mode video test pattern generator; successor to the fixed 4-bit gradient generator.
//  Sits between the video timing generator (x, y, visible, frame_start) and the output DAC/encoder.
//  Adds runtime mode selection with a frame-synchronous change handshake, horizontal scrolling animation and a 2-stage pipeline.
// PARAMETERS
//  CHAN_W      4     bits per colour channel (>=2)
//  COORD_W     16    width of x/y coordinates
//  H_ACTIVE    1024  active pixels per line (colour-bar width = H_ACTIVE/8, border position)
//  V_ACTIVE    768   active lines per frame (border position)
//  BAND_H      100   height in lines of each gradient band (mode 0)
//  CHECK_LOG2  5     checker square size = 2**CHECK_LOG2 pixels (mode 1)
//  SCROLL_STEP 1     pixels added to scroll offset per frame while scrolling
// PORTS
//  One clock; reset is asynchronous and active-low.
//  clk            in   1        pixel clock
//  rst_n          in   1        asynchronous active-low reset
//  x              in   COORD_W  current pixel column
//  y              in   COORD_W  current pixel line
//  visible        in   1        pixel is in the active area
//  frame_start    in   1        single-cycle pulse at start of each frame
//  mode_req       in   3        requested pattern mode
//  mode_req_valid in   1        mode_req is valid this cycle
//  scroll_en      in   1        advance scroll offset on each frame_start
//  mode_ack       out  1        1-cycle pulse: pending mode applied
//  mode_active    out  3        mode currently rendered
//  frame_cnt      out  8        frames since reset, wraps 255->0
//  r, g, b        out  CHAN_W   pixel colour
//  pix_valid      out  1        visible delayed to align with r/g/b
// BEHAVIOUR
//  Reset: r/g/b=0, pix_valid=0, mode_ack=0, mode_active=0, frame_cnt=0, scroll_off=0, no pending request.
//  Pipeline: latency 2 clocks from x/y/visible to r/g/b/pix_valid. S1: xs=x+scroll_off (mod 2**COORD_W), band/bar index.
//   S2: colour select. r/g/b forced 0 whenever delayed visible=0.
//  Modes (xs = scrolled x; y never scrolled; ramp=xs[CHAN_W+1:2], fine=xs[CHAN_W-1:0]):
//   0 GRADIENT: band=y/BAND_H by constant compares; bands 0..6 = R,G,B,RG,RB,GB,RGB ramp; band>=7: xs[7:6]=0/1/2/3 -> R/G/B/RGB fine ramp.
//   1 CHECKER: all channels full-scale if xs[CHECK_LOG2]^y[CHECK_LOG2], else 0.
//   2 COLOUR_BARS: 8 bars of H_ACTIVE/8: white,yellow,cyan,green,magenta,red,blue,black, full-scale; xs>=H_ACTIVE -> black.
//   3 FLAT_GREY: all channels = MSB only set (e.g. 4'b1000).  4..7 reserved: output black.
//  Mode handshake: mode_req_valid latches mode_req into pending (latest request overwrites).
//   On frame_start with pending (or mode_req_valid same cycle, which wins): mode_active<=request, pending cleared,
//   scroll_off<=0, mode_ack pulses next cycle. No frame_start -> request waits indefinitely. Re-requesting current mode still acks.
//  frame_cnt increments on every frame_start. scroll_off += SCROLL_STEP on frame_start when scroll_en=1 and no mode change; wraps mod 2**COORD_W; holds when scroll_en=0.
//  New mode/scroll take effect for pixels entering S1 the cycle after frame_start; in-flight pixels finish with old settings.
//  Reset mid-frame: outputs 0 immediately (async), resume in mode 0 at next valid pixel.
// CONFIGURATION
//  TPG_BORDER_EN defined: visible pixels with raw x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 forced all-channels full-scale in every mode (incl. reserved); same latency.
//  Not defined: no border override; logic absent.
// STRUCTURE
//  testpattern_pkg: mode enum (TPG_GRADIENT..TPG_FLAT_GREY), 8-entry colour-bar RGB table (1-bit per channel, expanded to CHAN_W), MODE_W=3.
//  Sub-module testpattern_mode_ctl: pending request, mode_active, mode_ack, frame_cnt, scroll_off. Top holds the pixel pipeline.
// TESTING
//  Mode 0, scroll_en=0, y=150, x=0x1C -> 2 cycles later g=4'h7, r=b=0, pix_valid=1; visible=0 -> r=g=b=0, pix_valid=0.
//  Mode 1, CHECK_LOG2=5: (x=32,y=0) -> all 4'hF; (x=32,y=32) -> all 0.
//  mode_req=2 valid mid-frame -> mode_active stays 0 until frame_start, then =2, mode_ack 1 cycle; x=128 -> r=g=4'hF, b=0 (yellow).
//  mode_req_valid coincident with frame_start -> applied that frame; two requests 3 then 1 before frame_start -> only 1 applied, one ack.
//  scroll_en=1, 3 frame_starts -> scroll_off=3; x=0 renders as xs=3; mode change -> scroll_off=0; frame_cnt wraps 255->0.
//  TPG_BORDER_EN: (x=0,y=10) and (x=H_ACTIVE-1) -> all 4'hF in mode 3; undefined -> 4'h8; assert rst_n mid-line -> outputs 0 same cycle.

Source files
------------

// File: rtl/testpattern_gen_pkg.sv
// Shared definitions for the test pattern generator: pattern modes and the colour-bar table.
package testpattern_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      TPG_GRADIENT    = 3'd0,
      TPG_CHECKER     = 3'd1,
      TPG_COLOUR_BARS = 3'd2,
      TPG_FLAT_GREY   = 3'd3
   } tpg_mode_e;

   // {R,G,B} on/off per bar, bar 0 in the low bits: white,yellow,cyan,green,magenta,red,blue,black
   localparam logic [23:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                      3'b010, 3'b011, 3'b110, 3'b111};

   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      return BAR_RGB[3*int'(idx) +: 3];
   endfunction

endpackage

// File: rtl/testpattern_gen_if.sv
// Mode-change handshake between a pattern requester (master) and the generator (slave).
interface testpattern_gen_if;
   import testpattern_pkg::*;

   logic [MODE_W-1:0] mode_req;
   logic              mode_req_valid;
   logic              mode_ack;
   logic [MODE_W-1:0] mode_active;

   modport master (output mode_req, mode_req_valid, input mode_ack, mode_active);
   modport slave  (input mode_req, mode_req_valid, output mode_ack, mode_active);

endinterface

// File: rtl/testpattern_gen_mode_ctl.sv
// Frame-synchronous mode control: pending request, active mode, ack pulse, frame counter, scroll offset.
module testpattern_mode_ctl
   import testpattern_pkg::*;
#(
   parameter int COORD_W     = 16,
   parameter int SCROLL_STEP = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start_i,
   input  logic [MODE_W-1:0]  mode_req_i,
   input  logic               mode_req_valid_i,
   input  logic               scroll_en_i,
   output logic [MODE_W-1:0]  mode_active_o,
   output logic               mode_ack_o,
   output logic [7:0]         frame_cnt_o,
   output logic [COORD_W-1:0] scroll_off_o
);

   logic               pend_q, pend_d;
   logic [MODE_W-1:0]  pend_mode_q, pend_mode_d;
   logic [MODE_W-1:0]  mode_q, mode_d;
   logic               ack_q, ack_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [COORD_W-1:0] scroll_q, scroll_d;
   logic               apply;

   always_comb begin
      apply       = frame_start_i & (mode_req_valid_i | pend_q);
      pend_d      = pend_q;
      pend_mode_d = pend_mode_q;
      mode_d      = mode_q;
      scroll_d    = scroll_q;
      ack_d       = apply;
      cnt_d       = frame_start_i ? cnt_q + 8'd1 : cnt_q;
      // A request arriving on the frame_start cycle itself beats the older pending one
      if (apply) begin
         mode_d   = mode_req_valid_i ? mode_req_i : pend_mode_q;
         pend_d   = 1'b0;
         scroll_d = '0;
      end else begin
         if (mode_req_valid_i) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_req_i;
         end
         if (frame_start_i && scroll_en_i)
            scroll_d = scroll_q + COORD_W'(SCROLL_STEP);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q      <= 1'b0;
         pend_mode_q <= '0;
         mode_q      <= '0;
         ack_q       <= 1'b0;
         cnt_q       <= '0;
         scroll_q    <= '0;
      end else begin
         pend_q      <= pend_d;
         pend_mode_q <= pend_mode_d;
         mode_q      <= mode_d;
         ack_q       <= ack_d;
         cnt_q       <= cnt_d;
         scroll_q    <= scroll_d;
      end
   end

   assign mode_active_o = mode_q;
   assign mode_ack_o    = ack_q;
   assign frame_cnt_o   = cnt_q;
   assign scroll_off_o  = scroll_q;

endmodule

// File: rtl/testpattern_gen.sv
// Multi-mode video test pattern generator with a 2-stage pixel pipeline.
// Optional macro TPG_BORDER_EN: forces a full-scale one-pixel frame border in every mode.
module testpattern_gen
   import testpattern_pkg::*;
#(
   parameter int CHAN_W      = 4,
   parameter int COORD_W     = 16,
   parameter int H_ACTIVE    = 1024,
   parameter int V_ACTIVE    = 768,
   parameter int BAND_H      = 100,
   parameter int CHECK_LOG2  = 5,
   parameter int SCROLL_STEP = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               visible,
   input  logic               frame_start,
   input  logic               scroll_en,
   testpattern_gen_if.slave   mode_if,
   output logic [7:0]         frame_cnt,
   output logic [CHAN_W-1:0]  r,
   output logic [CHAN_W-1:0]  g,
   output logic [CHAN_W-1:0]  b,
   output logic               pix_valid
);

   localparam int BAR_W = H_ACTIVE / 8;
   // {R,G,B} per gradient band 0..6, band 0 in the low bits: R,G,B,RG,RB,GB,RGB
   localparam logic [20:0] GRAD_MASK = {3'b111, 3'b011, 3'b101, 3'b110,
                                        3'b001, 3'b010, 3'b100};

   // Index of the step-wide slot holding v, saturating at 7; constant compares only
   function automatic logic [2:0] step_idx(input logic [COORD_W-1:0] v, input int step);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < 8; i++)
         if (32'(v) >= 32'(i * step)) idx = 3'(i);
      return idx;
   endfunction

   logic [MODE_W-1:0]  mode_active;
   logic               mode_ack;
   logic [COORD_W-1:0] scroll_off;

   testpattern_mode_ctl #(.COORD_W(COORD_W), .SCROLL_STEP(SCROLL_STEP)) u_mode_ctl (
      .clk              (clk),
      .rst_n            (rst_n),
      .frame_start_i    (frame_start),
      .mode_req_i       (mode_if.mode_req),
      .mode_req_valid_i (mode_if.mode_req_valid),
      .scroll_en_i      (scroll_en),
      .mode_active_o    (mode_active),
      .mode_ack_o       (mode_ack),
      .frame_cnt_o      (frame_cnt),
      .scroll_off_o     (scroll_off)
   );

   assign mode_if.mode_active = mode_active;
   assign mode_if.mode_ack    = mode_ack;

   // ---- Stage 1: scrolled x, band/bar index, per-mode selectors
   logic [COORD_W-1:0] xs_d;
   logic               vis_s1_q;
   logic [MODE_W-1:0]  mode_s1_q;
   logic [2:0]         band_s1_q, bar_s1_q;
   logic               bar_oob_s1_q, chk_s1_q;
   logic [CHAN_W-1:0]  ramp_s1_q, fine_s1_q;
   logic [1:0]         quad_s1_q;

   assign xs_d = x + scroll_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vis_s1_q <= 1'b0;
      else        vis_s1_q <= visible;
   end

   always_ff @(posedge clk) begin
      mode_s1_q    <= mode_active;
      band_s1_q    <= step_idx(y, BAND_H);
      bar_s1_q     <= step_idx(xs_d, BAR_W);
      bar_oob_s1_q <= 32'(xs_d) >= 32'(H_ACTIVE);
      chk_s1_q     <= xs_d[CHECK_LOG2] ^ y[CHECK_LOG2];
      ramp_s1_q    <= xs_d[CHAN_W+1:2];
      fine_s1_q    <= xs_d[CHAN_W-1:0];
      quad_s1_q    <= xs_d[7:6];
   end

`ifdef TPG_BORDER_EN
   logic border_s1_q;
   always_ff @(posedge clk) begin
      border_s1_q <= (x == '0) || (32'(x) == 32'(H_ACTIVE - 1)) ||
                     (y == '0) || (32'(y) == 32'(V_ACTIVE - 1));
   end
`endif

   // ---- Stage 2: colour select, blanking
   logic [2:0]        mask;
   logic [CHAN_W-1:0] lvl;

   always_comb begin
      mask = 3'b000;
      lvl  = '0;
      case (mode_s1_q)
         TPG_GRADIENT: begin
            if (band_s1_q != 3'd7) begin
               lvl  = ramp_s1_q;
               mask = GRAD_MASK[3*int'(band_s1_q) +: 3];
            end else begin
               lvl = fine_s1_q;
               case (quad_s1_q)
                  2'd0:    mask = 3'b100;
                  2'd1:    mask = 3'b010;
                  2'd2:    mask = 3'b001;
                  default: mask = 3'b111;
               endcase
            end
         end
         TPG_CHECKER: begin
            lvl  = '1;
            mask = chk_s1_q ? 3'b111 : 3'b000;
         end
         TPG_COLOUR_BARS: begin
            lvl  = '1;
            mask = bar_oob_s1_q ? 3'b000 : bar_rgb(bar_s1_q);
         end
         TPG_FLAT_GREY: begin
            lvl  = {1'b1, {(CHAN_W-1){1'b0}}};
            mask = 3'b111;
         end
         default: mask = 3'b000;
      endcase
`ifdef TPG_BORDER_EN
      if (border_s1_q) begin
         lvl  = '1;
         mask = 3'b111;
      end
`endif
      if (!vis_s1_q) mask = 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r         <= '0;
         g         <= '0;
         b         <= '0;
         pix_valid <= 1'b0;
      end else begin
         r         <= mask[2] ? lvl : '0;
         g         <= mask[1] ? lvl : '0;
         b         <= mask[0] ? lvl : '0;
         pix_valid <= vis_s1_q;
      end
   end

endmodule

// File: tb/tb_testpattern_gen.sv
// Randomised bench for testpattern_gen against a frame-level behavioural model, plus directed cases.
module tb_testpattern_gen;

   localparam int CW = 4, CRD = 16, H = 1024, V = 768, BAND = 100, CL = 5, STEP = 1;
`ifdef TPG_BORDER_EN
   localparam logic [11:0] EDGE_RGB = 12'hFFF;
`else
   localparam logic [11:0] EDGE_RGB = 12'h888;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [CRD-1:0] x, y;
   logic           visible, frame_start, scroll_en;
   logic [7:0]     frame_cnt;
   logic [CW-1:0]  r, g, b;
   logic           pix_valid;

   testpattern_gen_if mif();

   testpattern_gen #(.CHAN_W(CW), .COORD_W(CRD), .H_ACTIVE(H), .V_ACTIVE(V),
                     .BAND_H(BAND), .CHECK_LOG2(CL), .SCROLL_STEP(STEP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (x),
      .y           (y),
      .visible     (visible),
      .frame_start (frame_start),
      .scroll_en   (scroll_en),
      .mode_if     (mif.slave),
      .frame_cnt   (frame_cnt),
      .r           (r),
      .g           (g),
      .b           (b),
      .pix_valid   (pix_valid)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int m_mode, m_pend, m_pmode, m_scroll, m_fcnt, m_ack;
   int exp_s1, exp_s2;
   int ack_seen;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected {pix_valid, r, g, b} for one pixel, straight from the pattern definitions
   function automatic int ref_pix(int mode, int scroll, int xr, int yr, bit vis);
      int grad_m[7] = '{4, 2, 1, 6, 5, 3, 7};
      int quad_m[4] = '{4, 2, 1, 7};
      int bar_c[8]  = '{7, 6, 3, 2, 5, 4, 1, 0};
      int xs, lvl, mask, band;
      if (!vis) return 0;
      xs = (xr + scroll) % 65536;
      lvl = 0;
      mask = 0;
      case (mode)
         0: begin
            band = yr / BAND;
            if (band < 7) begin lvl = (xs / 4) % 16; mask = grad_m[band]; end
            else begin lvl = xs % 16; mask = quad_m[(xs / 64) % 4]; end
         end
         1: begin lvl = 15; mask = (((xs >> CL) ^ (yr >> CL)) & 1) ? 7 : 0; end
         2: begin lvl = 15; mask = (xs >= H) ? 0 : bar_c[xs / (H / 8)]; end
         3: begin lvl = 8; mask = 7; end
         default: mask = 0;
      endcase
`ifdef TPG_BORDER_EN
      if (xr == 0 || xr == H - 1 || yr == 0 || yr == V - 1) begin lvl = 15; mask = 7; end
`endif
      return (1 << 12) | (((mask & 4) != 0) ? lvl << 8 : 0) |
             (((mask & 2) != 0) ? lvl << 4 : 0) | (((mask & 1) != 0) ? lvl : 0);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pend = 0; m_pmode = 0; m_scroll = 0; m_fcnt = 0; m_ack = 0;
      exp_s1 = 0; exp_s2 = 0;
   endtask

   // One clock: advance model with the inputs present at the edge, then compare every output
   task automatic cyc();
      bit apply;
      @(posedge clk);
      #1;
      exp_s2 = exp_s1;
      exp_s1 = ref_pix(m_mode, m_scroll, int'(x), int'(y), visible);
      apply = frame_start && (mif.mode_req_valid || m_pend != 0);
      m_ack = apply ? 1 : 0;
      if (frame_start) m_fcnt = (m_fcnt + 1) % 256;
      if (apply) begin
         m_mode = mif.mode_req_valid ? int'(mif.mode_req) : m_pmode;
         m_pend = 0;
         m_scroll = 0;
      end else begin
         if (mif.mode_req_valid) begin m_pend = 1; m_pmode = int'(mif.mode_req); end
         if (frame_start && scroll_en) m_scroll = (m_scroll + STEP) % 65536;
      end
      if (mif.mode_ack === 1'b1) ack_seen++;
      check_eq("pix", 32'({pix_valid, r, g, b}), exp_s2);
      check_eq("mode_active", 32'(mif.mode_active), m_mode);
      check_eq("mode_ack", 32'(mif.mode_ack), m_ack);
      check_eq("frame_cnt", 32'(frame_cnt), m_fcnt);
   endtask

   task automatic pix(input int xv, input int yv, input bit vis);
      x = 16'(xv); y = 16'(yv); visible = vis;
   endtask

   task automatic switch_mode(input int md);
      mif.mode_req = 3'(md); mif.mode_req_valid = 1'b1; frame_start = 1'b1;
      cyc();
      mif.mode_req_valid = 1'b0; frame_start = 1'b0;
   endtask

   task automatic show(input int xv, input int yv);
      pix(xv, yv, 1'b1);
      cyc();
      cyc();
   endtask

   initial begin
      rst_n = 1'b0;
      x = '0; y = '0; visible = 1'b0; frame_start = 1'b0; scroll_en = 1'b0;
      mif.mode_req = '0; mif.mode_req_valid = 1'b0;
      model_reset();
      ack_seen = 0;
      #2;
      check_eq("rst_pix", 32'({pix_valid, r, g, b}), 0);
      check_eq("rst_mode", 32'(mif.mode_active), 0);
      check_eq("rst_ack", 32'(mif.mode_ack), 0);
      check_eq("rst_fcnt", 32'(frame_cnt), 0);
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;

      // Gradient band 1 (green ramp), then blanking
      show(28, 150);
      check_eq("grad_rgb", 32'({r, g, b}), 12'h070);
      check_eq("grad_pv", 32'(pix_valid), 1);
      pix(28, 150, 1'b0);
      cyc(); cyc();
      check_eq("blank", 32'({pix_valid, r, g, b}), 0);

      // Mid-frame request waits for frame_start
      mif.mode_req = 3'd1; mif.mode_req_valid = 1'b1;
      cyc();
      mif.mode_req_valid = 1'b0;
      repeat (3) cyc();
      check_eq("req_wait", 32'(mif.mode_active), 0);
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      check_eq("req_apply", 32'(mif.mode_active), 1);
      check_eq("ack_pulse", 32'(mif.mode_ack), 1);
      cyc();
      check_eq("ack_clear", 32'(mif.mode_ack), 0);
      show(32, 0);
      check_eq("chk_on", 32'({r, g, b}), 12'hFFF);
      show(32, 32);
      check_eq("chk_off", 32'({r, g, b}), 12'h000);

      // Colour bars: bar 1 is yellow
      mif.mode_req = 3'd2; mif.mode_req_valid = 1'b1;
      cyc();
      mif.mode_req_valid = 1'b0;
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      check_eq("bars_mode", 32'(mif.mode_active), 2);
      show(128, 10);
      check_eq("bars_yellow", 32'({r, g, b}), 12'hFF0);

      // Request coincident with frame_start; then two queued requests, last wins
      switch_mode(3);
      check_eq("coinc_mode", 32'(mif.mode_active), 3);
      check_eq("coinc_ack", 32'(mif.mode_ack), 1);
      ack_seen = 0;
      mif.mode_req = 3'd3; mif.mode_req_valid = 1'b1; cyc();
      mif.mode_req = 3'd1; cyc();
      mif.mode_req_valid = 1'b0; cyc();
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      repeat (4) cyc();
      check_eq("last_req_wins", 32'(mif.mode_active), 1);
      check_eq("single_ack", 32'(ack_seen), 1);

      // Flat grey, and border pixels
      switch_mode(3);
      show(5, 10);
      check_eq("grey", 32'({r, g, b}), 12'h888);
      show(0, 10);
      check_eq("edge_left", 32'({r, g, b}), 32'(EDGE_RGB));
      show(H - 1, 10);
      check_eq("edge_right", 32'({r, g, b}), 32'(EDGE_RGB));

      // Scroll three frames, then a mode change clears the offset
      switch_mode(0);
      scroll_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         frame_start = 1'b1; cyc(); frame_start = 1'b0; cyc();
      end
      scroll_en = 1'b0;
      show(1, 700);
      check_eq("scroll3", 32'({r, g, b}), 12'h400);
      switch_mode(0);
      show(1, 700);
      check_eq("scroll_clr", 32'({r, g, b}), 12'h100);

      // frame_cnt wrap
      for (int i = 0; i < 600 && m_fcnt != 255; i++) begin
         frame_start = 1'b1; cyc(); frame_start = 1'b0; cyc();
      end
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      check_eq("fcnt_wrap", 32'(frame_cnt), 0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         pix($urandom_range(0, 1100), $urandom_range(0, 800), $urandom_range(0, 7) != 0);
         frame_start = ($urandom_range(0, 15) == 0);
         mif.mode_req_valid = ($urandom_range(0, 9) == 0);
         mif.mode_req = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) scroll_en = ~scroll_en;
         cyc();
      end
      frame_start = 1'b0; mif.mode_req_valid = 1'b0; scroll_en = 1'b0;

      // Reset in the middle of a visible line
      switch_mode(3);
      pix(5, 20, 1'b1);
      repeat (4) cyc();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_pix", 32'({pix_valid, r, g, b}), 0);
      check_eq("midrst_mode", 32'(mif.mode_active), 0);
      model_reset();
      pix(0, 0, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      show(28, 150);
      check_eq("post_rst_grad", 32'({r, g, b}), 12'h070);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
